// File: rtl/comp_pkg.sv
// Shared definitions for the round-robin compare arbiter: result encoding and default operand width.
package comp_pkg;

    localparam logic [1:0] CMP_SMALL = 2'd0;
    localparam logic [1:0] CMP_EQ    = 2'd1;
    localparam logic [1:0] CMP_BIG   = 2'd2;

    localparam int DEF_W = 4;

endpackage

// File: rtl/comp_core.sv
// Purely combinational unsigned W-bit magnitude compare producing big/equal/small.
module comp_core
    import comp_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_big,
    output logic         o_eq,
    output logic         o_small
);

    logic [1:0] w_code;

    always_comb begin
        if (i_a > i_b)       w_code = CMP_BIG;
        else if (i_a == i_b) w_code = CMP_EQ;
        else                 w_code = CMP_SMALL;
    end

    assign o_big   = (w_code == CMP_BIG);
    assign o_eq    = (w_code == CMP_EQ);
    assign o_small = (w_code == CMP_SMALL);

endmodule

// File: rtl/comp_rr_arbiter.sv
// Round-robin arbiter sharing one comparator among N_REQ requesters, with a valid/ready result stage.
// Define COMP_RR_ARBITER_STATS_EN to add the grant / equal-grant statistics counters.
module comp_rr_arbiter
    import comp_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = DEF_W,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic               res_big,
    output logic               res_eq,
    output logic               res_small
`ifdef COMP_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]        stat_cnt,
    output logic [15:0]        stat_eq_cnt
`endif
);

    logic [ID_W-1:0] r_ptr;
    logic            r_valid;
    logic [ID_W-1:0] r_id;
    logic            r_big;
    logic            r_eq;
    logic            r_small;

    logic            w_can_issue;
    logic            w_grant;
    logic [ID_W-1:0] w_gnt_idx;
    logic [ID_W-1:0] w_cand;
    logic [ID_W-1:0] w_ptr_next;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_big;
    logic            w_eq;
    logic            w_small;

    // Output stage may accept a new result when empty or being drained this cycle.
    assign w_can_issue = ~r_valid | res_ready;

    always_comb begin
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        if (!rst && w_can_issue) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
                if (!w_grant && req[w_cand]) begin
                    w_grant   = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
    end

    assign gnt        = w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_next = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    assign w_a = a_in[int'(w_gnt_idx)*W +: W];
    assign w_b = b_in[int'(w_gnt_idx)*W +: W];

    comp_core #(.W(W)) u_comp_core (
        .i_a     (w_a),
        .i_b     (w_b),
        .o_big   (w_big),
        .o_eq    (w_eq),
        .o_small (w_small)
    );

    // EMPTY/FULL output stage: a grant always (re)loads, a drain without grant empties, a stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_big   <= 1'b0;
            r_eq    <= 1'b0;
            r_small <= 1'b0;
            r_ptr   <= '0;
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_id    <= w_gnt_idx;
            r_big   <= w_big;
            r_eq    <= w_eq;
            r_small <= w_small;
            r_ptr   <= w_ptr_next;
        end else if (res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign res_valid = r_valid;
    assign res_id    = r_id;
    assign res_big   = r_big;
    assign res_eq    = r_eq;
    assign res_small = r_small;

`ifdef COMP_RR_ARBITER_STATS_EN
    logic [15:0] r_stat_cnt;
    logic [15:0] r_stat_eq_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt    <= '0;
            r_stat_eq_cnt <= '0;
        end else if (w_grant) begin
            r_stat_cnt <= r_stat_cnt + 16'd1;
            if (w_eq) r_stat_eq_cnt <= r_stat_eq_cnt + 16'd1;
        end
    end

    assign stat_cnt    = r_stat_cnt;
    assign stat_eq_cnt = r_stat_eq_cnt;
`endif

endmodule

// File: doc/comp_rr_arbiter.md
Name: comp_rr_arbiter

Overview:
- Shares one 4-bit magnitude comparator (big/equal/small) among N_REQ requesters.
- Round-robin arbitration; at most one comparison issued per cycle.
- Result is registered into a single-entry output stage with valid/ready backpressure, tagged with the requester id.
- Sits between requesting control FSMs and the shared compare datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand width in bits
- ID_W, $clog2(N_REQ), width of the result id tag (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester request; held high with stable operands until granted
- a_in  in  N_REQ*W  packed operand A; requester i occupies bits [i*W +: W]
- b_in  in  N_REQ*W  packed operand B; same packing as a_in
- gnt  out  N_REQ  one-hot combinational grant; operands of the granted requester are captured this edge
- res_valid  out  1  output stage holds a result
- res_ready  in  1  consumer accepts result when res_valid & res_ready
- res_id  out  ID_W  index of the requester that owns the result
- res_big  out  1  a > b (unsigned)
- res_eq  out  1  a == b
- res_small  out  1  a < b

Behaviour:
- Reset (rst=1 at edge): res_valid=0, res_id=0, res_big/eq/small=0, rr pointer ptr=0, stats counter=0. gnt=0 while rst=1.
- Issue condition: can_issue = ~res_valid | res_ready. Output stage is free, or is being drained this cycle.
- Arbitration: when can_issue, the granted requester is the first req[i] set, searching from i=ptr upward with wrap modulo N_REQ. Otherwise gnt=0.
- gnt is combinational and one-hot or zero. A requester sees gnt[i]=1 in the same cycle its operands are consumed. It drops req or presents new operands the next cycle.
- On a grant to i at a clock edge:
  - res_valid<=1, res_id<=i, and the flags are loaded from the compare of a_in/b_in slice i.
  - ptr<=(i+1) mod N_REQ.
- No grant while can_issue: if res_ready was asserted, res_valid<=0. ptr is unchanged.
- Stall (res_valid & ~res_ready): the output register holds, gnt=0, and ptr is unchanged.
- Latency: grant to res_valid is 1 cycle. Full throughput is 1 result/cycle when res_ready is held high.
- Compare: unsigned, W bits. Exactly one of big/eq/small is 1 whenever res_valid=1.
- Fairness: any continuously asserted req is granted within N_REQ issue opportunities.
- Simultaneous drain and issue: res_ready & res_valid together with a new grant replaces the result in the same edge with no bubble.
- Reset mid-operation: a pending result is discarded and pending requests are not granted. After reset, arbitration restarts from ptr=0.
- req deasserted before grant: nothing is recorded; no state change.
- FSM: implicit 2-state output stage, EMPTY (res_valid=0) / FULL (res_valid=1).
  - EMPTY->FULL on grant.
  - FULL->EMPTY on ready with no grant.
  - FULL->FULL on ready with grant, or on stall.

Optional Feature:
- Macro: COMP_RR_ARBITER_STATS_EN.
- Defined:
  - Extra outputs stat_cnt (16 bits) and stat_eq_cnt (16 bits).
  - stat_cnt counts grants; stat_eq_cnt counts grants whose compare is equal.
  - Both wrap modulo 2^16 and are cleared by rst.
- Undefined: the ports and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (comp_pkg): localparams for result encoding CMP_BIG=2'd2, CMP_EQ=2'd1, CMP_SMALL=2'd0, and the default operand width.
- Sub-module comp_core: purely combinational W-bit compare producing big/eq/small, instantiated once after the operand mux.
- Round-robin select logic stays in the top module.

Test Plan:
- Reset: assert rst with all req=1 for 2 cycles -> gnt=0, res_valid=0, all flags 0; first grant after release goes to requester 0.
- Single requester: req=4'b0100, a2=9, b2=3, res_ready=1 -> gnt=4'b0100; next cycle res_valid=1, res_id=2, res_big=1.
- Round-robin: req=4'b1111 held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_id follows one cycle later with no bubbles.
- Backpressure: after a grant, hold res_ready=0 for 3 cycles with req=4'b0011 -> gnt=0 and the result stays stable; on res_ready=1, the next grant issues that same cycle.
- Equality/boundary: a=15,b=15 -> res_eq=1. a=0,b=15 -> res_small=1. a=15,b=0 -> res_big=1. Exactly one flag is set in each case.
- Reset mid-stream: rst=1 while res_valid=1 and ptr=2 -> res_valid=0 next cycle; after release with req=4'b1111, the first grant goes to requester 0.
